// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back stage.
//   DATA_W / ADDR_W : register data width and register address width
//   FIFO_DEPTH      : default depth of the load-result FIFO (power of 2, >= 2)
//   state_e         : write-back FSM states (IDLE, HI)
//   grant_e         : which source received the most recent grant
//   wb_entry_t      : one pending register write {addr, data}
package regfile_writeback_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } state_e;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle around the write-back stage.
//   alu_*  : ALU result offer (valid/ready), optional 64-bit result via alu_wide/alu_data_hi
//   mem_*  : load result offer (valid/ready), buffered in the load FIFO
//   wr_*   : register file write port
//   busy   : stage still holds or is issuing work
// master = result producers / register file side, slave = write-back stage.
interface regfile_writeback_if;
    import regfile_writeback_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_wide;
    logic [DATA_W-1:0] alu_data_hi;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              wr_enable;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output alu_valid, alu_addr, alu_data, alu_wide, alu_data_hi,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, wr_enable, wr_address, wr_data, busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, alu_wide, alu_data_hi,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, wr_enable, wr_address, wr_data, busy
    );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO of pending load writes.
//   clk, clr    : clock, asynchronous active-high reset (contents are lost)
//   push, din   : write an entry (ignored when full)
//   pop, dout   : dout is the head entry; pop removes it (ignored when empty)
//   full, empty : occupancy flags
// Push and pop in the same cycle leave the occupancy unchanged.
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      clr,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of the always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of 2, so the pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only read
    // after it has been written, and the reset pointers make stale data invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage feeding the single write port of the 16x32 register file.
//   clk, clr : clock, asynchronous active-high reset
//   bus      : slave side of regfile_writeback_if (ALU offer, load offer,
//              registered write port, busy)
// ALU results and buffered loads are arbitrated round-robin, one write per
// cycle. A wide ALU result is written as LO->rd then HI->rd+1 (mod 16).
// DATA_W / ADDR_W come from the package since the interface shares them.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                clr,
    regfile_writeback_if.slave  bus
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0] hi_data_q, hi_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              alu_ready;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    wb_entry_t         fifo_din, fifo_dout;

    assign fifo_push = bus.mem_valid && !fifo_full;
    assign fifo_din  = '{addr: bus.mem_addr, data: bus.mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hi_addr_d    = hi_addr_q;
        hi_data_d    = hi_data_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        alu_ready    = 1'b0;
        fifo_pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The ALU wins unless the FIFO is waiting and the ALU had the
                // previous grant; any non-ALU cycle with loads pending pops one.
                alu_ready = fifo_empty || (last_grant_q == GNT_MEM);
                if (bus.alu_valid && alu_ready) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = bus.alu_addr;
                    wr_data_d    = bus.alu_data;
                    last_grant_d = GNT_ALU;
                    if (bus.alu_wide) begin
                        hi_addr_d = bus.alu_addr + ADDR_W'(1);  // 15 wraps to 0
                        hi_data_d = bus.alu_data_hi;
                        state_d   = ST_HI;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_addr_d    = fifo_dout.addr;
                    wr_data_d    = fifo_dout.data;
                    last_grant_d = GNT_MEM;
                end
            end
            ST_HI: begin
                wr_en_d   = 1'b1;
                wr_addr_d = hi_addr_q;
                wr_data_d = hi_data_q;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_ALU;
            hi_addr_q    <= '0;
            hi_data_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hi_addr_q    <= hi_addr_d;
            hi_data_q    <= hi_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.mem_ready  = !fifo_full;
    assign bus.wr_enable  = wr_en_q;
    assign bus.wr_address = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = !fifo_empty || (state_q == ST_HI) || wr_en_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: reset state, a table of single
// and wide ALU writes, reset during a HI beat, contention, FIFO fill and
// randomized traffic, all scored by a cycle-level reference model.
module tb_regfile_writeback;
    import regfile_writeback_pkg::*;

    localparam int N_DEPTH = FIFO_DEPTH;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_writeback_if bus ();

    regfile_writeback #(.DEPTH(N_DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Loads waiting to be written are kept in a queue in push order; the
    // model decides each cycle which write must appear on the port next.
    typedef enum {SRC_NONE, SRC_ALU, SRC_MEM, SRC_HI} src_e;

    wb_entry_t         mem_model [$];
    wb_entry_t         head;
    src_e              exp_src  = SRC_NONE;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_data = '0;
    bit                hi_pend  = 1'b0;
    logic [ADDR_W-1:0] hi_addr  = '0;
    logic [DATA_W-1:0] hi_data  = '0;
    bit                last_mem = 1'b0;
    int                occ;
    int                wr_count = 0;

    always @(negedge clk) begin
        #3;
        if (clr) begin
            check("reset_wr_enable", 64'(bus.wr_enable), 64'(0));
            check("reset_busy", 64'(bus.busy), 64'(0));
            mem_model.delete();
            exp_src  = SRC_NONE;
            hi_pend  = 1'b0;
            last_mem = 1'b0;
        end else begin
            if (bus.wr_enable) wr_count++;
            if (exp_src == SRC_NONE) begin
                check("no_grant_no_write", 64'(bus.wr_enable), 64'(0));
            end else begin
                if (exp_src == SRC_MEM) begin
                    head     = mem_model.pop_front();
                    exp_addr = head.addr;
                    exp_data = head.data;
                end
                check("write_strobe", 64'(bus.wr_enable), 64'(1));
                check("write_address", 64'(bus.wr_address), 64'(exp_addr));
                check("write_data", 64'(bus.wr_data), 64'(exp_data));
            end

            occ = mem_model.size();
            check("mem_ready", 64'(bus.mem_ready), 64'(occ < N_DEPTH));
            check("alu_ready", 64'(bus.alu_ready), 64'(!hi_pend && (occ == 0 || last_mem)));
            check("busy", 64'(bus.busy), 64'(occ > 0 || hi_pend || bus.wr_enable));

            if (hi_pend) begin
                exp_src  = SRC_HI;
                exp_addr = hi_addr;
                exp_data = hi_data;
                hi_pend  = 1'b0;
            end else if (bus.alu_valid && (occ == 0 || last_mem)) begin
                exp_src  = SRC_ALU;
                exp_addr = bus.alu_addr;
                exp_data = bus.alu_data;
                last_mem = 1'b0;
                if (bus.alu_wide) begin
                    hi_pend = 1'b1;
                    hi_addr = ADDR_W'((int'(bus.alu_addr) + 1) % (1 << ADDR_W));
                    hi_data = bus.alu_data_hi;
                end
            end else if (occ > 0) begin
                exp_src  = SRC_MEM;
                last_mem = 1'b1;
            end else begin
                exp_src = SRC_NONE;
            end

            if (bus.mem_valid && occ < N_DEPTH)
                mem_model.push_back('{addr: bus.mem_addr, data: bus.mem_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_addr    = '0;
        bus.alu_data    = '0;
        bus.alu_wide    = 1'b0;
        bus.alu_data_hi = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data    = '0;
    endtask

    // Offers held until accepted; n_beats counts register writes owed.
    task automatic run_cycles(input int n, input int p_alu, input int p_wide, input int p_mem,
                              input int mem_budget, output int n_beats, output bit saw_full);
        bit alu_taken = 1'b1;
        bit mem_taken = 1'b1;
        int pushes    = 0;
        n_beats  = 0;
        saw_full = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (alu_taken || !bus.alu_valid) begin
                bus.alu_valid   = ($urandom_range(99) < p_alu);
                bus.alu_addr    = ADDR_W'($urandom);
                bus.alu_data    = $urandom;
                bus.alu_wide    = ($urandom_range(99) < p_wide);
                bus.alu_data_hi = $urandom;
            end
            if (mem_taken || !bus.mem_valid) begin
                bus.mem_valid = (pushes < mem_budget) && ($urandom_range(99) < p_mem);
                bus.mem_addr  = ADDR_W'($urandom);
                bus.mem_data  = $urandom;
            end
            #2;
            alu_taken = bus.alu_valid && bus.alu_ready;
            mem_taken = bus.mem_valid && bus.mem_ready;
            if (alu_taken) n_beats += bus.alu_wide ? 2 : 1;
            if (mem_taken) begin
                n_beats++;
                pushes++;
            end
            if (!bus.mem_ready) saw_full = 1'b1;
        end
        @(negedge clk);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (bus.busy && k < budget);
        check("drain_busy", 64'(bus.busy), 64'(0));
    endtask

    task automatic traffic(input string name, input int n, input int p_alu, input int p_wide,
                           input int p_mem, input int mem_budget, output bit saw_full);
        int beats;
        int start = wr_count;
        run_cycles(n, p_alu, p_wide, p_mem, mem_budget, beats, saw_full);
        drain(60);
        check({name, "_write_count"}, 64'(wr_count - start), 64'(beats));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wide;
        logic [DATA_W-1:0] data_hi;
        logic [ADDR_W-1:0] e_addr0;
        logic [DATA_W-1:0] e_data0;
        logic              e_second;
        logic [ADDR_W-1:0] e_addr1;
        logic [DATA_W-1:0] e_data1;
    } vec_t;

    vec_t vecs [5];
    bit   full_seen;

    initial begin
        vecs[0] = '{4'd3,  32'h1234_5678, 1'b0, 32'h0,         4'd3,  32'h1234_5678, 1'b0, 4'd0,  32'h0};
        vecs[1] = '{4'd15, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002, 4'd15, 32'hAAAA_0001, 1'b1, 4'd0,  32'hBBBB_0002};
        vecs[2] = '{4'd0,  32'hFFFF_FFFF, 1'b0, 32'h5555_5555, 4'd0,  32'hFFFF_FFFF, 1'b0, 4'd0,  32'h0};
        vecs[3] = '{4'd7,  32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 4'd7,  32'h0000_0000, 1'b1, 4'd8,  32'hDEAD_BEEF};
        vecs[4] = '{4'd14, 32'h0000_0005, 1'b1, 32'h0000_0006, 4'd14, 32'h0000_0005, 1'b1, 4'd15, 32'h0000_0006};

        idle_inputs();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        #2;
        check("rst_wr_enable", 64'(bus.wr_enable), 64'(0));
        check("rst_wr_address", 64'(bus.wr_address), 64'(0));
        check("rst_wr_data", 64'(bus.wr_data), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_alu_ready", 64'(bus.alu_ready), 64'(1));
        check("rst_mem_ready", 64'(bus.mem_ready), 64'(1));

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.alu_valid   = 1'b1;
            bus.alu_addr    = vecs[i].addr;
            bus.alu_data    = vecs[i].data;
            bus.alu_wide    = vecs[i].wide;
            bus.alu_data_hi = vecs[i].data_hi;
            #2;
            check("tbl_alu_ready", 64'(bus.alu_ready), 64'(1));
            @(negedge clk);
            bus.alu_valid = 1'b0;
            #2;
            check("tbl_lo_strobe", 64'(bus.wr_enable), 64'(1));
            check("tbl_lo_address", 64'(bus.wr_address), 64'(vecs[i].e_addr0));
            check("tbl_lo_data", 64'(bus.wr_data), 64'(vecs[i].e_data0));
            if (vecs[i].wide) check("tbl_hi_alu_ready", 64'(bus.alu_ready), 64'(0));
            @(negedge clk);
            #2;
            check("tbl_second_strobe", 64'(bus.wr_enable), 64'(vecs[i].e_second));
            if (vecs[i].e_second) begin
                check("tbl_hi_address", 64'(bus.wr_address), 64'(vecs[i].e_addr1));
                check("tbl_hi_data", 64'(bus.wr_data), 64'(vecs[i].e_data1));
            end
            @(negedge clk);
            #2;
            check("tbl_quiet_strobe", 64'(bus.wr_enable), 64'(0));
            check("tbl_quiet_busy", 64'(bus.busy), 64'(0));
        end

        // Reset while the HI beat of a wide result is pending.
        @(negedge clk);
        bus.alu_valid   = 1'b1;
        bus.alu_addr    = 4'd5;
        bus.alu_data    = 32'h0101_0101;
        bus.alu_wide    = 1'b1;
        bus.alu_data_hi = 32'h0202_0202;
        @(negedge clk);
        bus.alu_valid = 1'b0;
        clr = 1'b1;
        #2;
        check("clr_hi_wr_enable", 64'(bus.wr_enable), 64'(0));
        check("clr_hi_busy", 64'(bus.busy), 64'(0));
        check("clr_hi_wr_address", 64'(bus.wr_address), 64'(0));
        @(negedge clk);
        clr = 1'b0;
        #2;
        check("post_clr_wr_enable", 64'(bus.wr_enable), 64'(0));
        @(negedge clk);
        #2;
        check("no_hi_after_clr", 64'(bus.wr_enable), 64'(0));
        check("no_hi_after_clr_busy", 64'(bus.busy), 64'(0));

        // Contention straight after reset: both sources valid for 6 cycles.
        traffic("contention", 6, 100, 0, 100, 6, full_seen);

        // ALU streaming wide results while 7 loads arrive back to back.
        traffic("fifo_fill", 12, 100, 100, 100, 7, full_seen);
        check("fifo_fill_mem_ready_dropped", 64'(full_seen), 64'(1));

        // Randomized traffic with different mixes.
        traffic("rand_mixed", 300, 50, 30, 50, 1000, full_seen);
        traffic("rand_heavy", 300, 90, 60, 90, 1000, full_seen);
        traffic("rand_loads", 300, 20, 10, 95, 1000, full_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
